rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single-port, 1-cycle-latency instruction ROM between the CPU fetch path (driven by ip)
//  and the CPU data-load path (constant tables in ROM).
//  Arbitrates one access per cycle and returns read data one cycle after grant.
//  Enforces the valid-ip bound: a fetch past IP_LIMIT halts the CPU permanently, replacing the
//  bench-side "IP is too big" check.
// PARAMETERS
//  ROM_SIZE   512   ROM depth in 32-bit words; rom_addr width = $clog2(ROM_SIZE)
//  IP_LIMIT   318   highest legal fetch address; fetch to a higher address -> HALT
//  STARVE_MAX 3     consecutive denied fetch cycles after which fetch gets priority (1..15)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  if_req     in   1   fetch request, held until if_gnt
//  if_addr    in   16  fetch address (ip)
//  if_gnt     out  1   fetch accepted this cycle
//  if_rvalid  out  1   if_rdata valid (cycle after if_gnt)
//  if_rdata   out  32  fetched instruction word
//  ld_req     in   1   load request, held until ld_gnt
//  ld_addr    in   16  load word address
//  ld_gnt     out  1   load accepted this cycle
//  ld_rvalid  out  1   ld_rdata / ld_err valid (cycle after ld_gnt)
//  ld_rdata   out  32  loaded word; 0 when ld_err
//  ld_err     out  1   load address >= ROM_SIZE; qualified by ld_rvalid
//  rom_en     out  1   ROM read enable
//  rom_addr   out  $clog2(ROM_SIZE)  ROM word address
//  rom_rdata  in   32  ROM data, valid the cycle after rom_en
//  halt       out  1   sticky: CPU must stop; set on illegal fetch
//  halt_addr  out  16  if_addr that caused halt
//  stall_cnt  out  32  ROM_ARB_STATS_EN only: cycles a request was pending but not granted
// BEHAVIOUR
//  Reset (async, rst=1): every output 0, FSM=RUN, starve counter=0, pending-return tags cleared.
//   - rst asserted mid-access drops the in-flight return: no rvalid after release.
//  FSM RUN:
//   - if_req && if_addr>IP_LIMIT -> go HALT next edge, latch halt_addr, no grant that cycle.
//   - Both legal requests: ld wins unless starve_cnt==STARVE_MAX, then if wins.
//   - starve_cnt: +1 when if_req denied; cleared on if_gnt; saturates at STARVE_MAX.
//   - Single requester is granted immediately; gnt is combinational from req in RUN.
//  FSM HALT: if_gnt=ld_gnt=0, rom_en=0, halt=1; only exit is rst.
//   - A return already in flight still completes.
//  Grant/access:
//   - gnt -> rom_en=1, rom_addr=addr[$clog2(ROM_SIZE)-1:0] same cycle.
//   - Next cycle: winner's rvalid=1, rdata=rom_rdata.
//   - rvalid is a 1-cycle pulse; rdata holds its last value otherwise.
//  Latency / throughput: 1 cycle grant->data, one access per cycle, back-to-back grants allowed.
//  Load range error: ld_addr>=ROM_SIZE is granted without a ROM access (rom_en=0);
//   next cycle ld_rvalid=1, ld_err=1, ld_rdata=0.
//  Fetch is never out of ROM range in RUN: IP_LIMIT < ROM_SIZE is required
//   (elaboration $error otherwise).
//  Same cycle illegal fetch + legal load: load is granted, HALT entered at the same edge.
// CONFIGURATION
//  ROM_ARB_STATS_EN defined:
//   - stall_cnt port present.
//   - +1 each cycle in RUN where (if_req && !if_gnt) || (ld_req && !ld_gnt); counts once per
//     cycle even if both wait.
//   - Wraps at 2^32; reset to 0.
//  ROM_ARB_STATS_EN undefined: stall_cnt port and counter absent; behaviour otherwise identical.
// TESTING
//  1 fetch only: if_req, if_addr=5, ROM[5]=32'hDEADBEEF
//    -> if_gnt same cycle, if_rvalid next cycle with if_rdata=32'hDEADBEEF.
//  2 contention: if_req+ld_req held 5 cycles, STARVE_MAX=3
//    -> grants ld,ld,ld,if,ld; each rvalid 1 cycle after its gnt.
//  3 bound: if_addr=319
//    -> no grant, halt=1 next edge, halt_addr=319.
//    -> further if_req/ld_req never granted; halt cleared only by rst.
//  4 load error: ld_addr=600
//    -> ld_gnt, rom_en=0, next cycle ld_rvalid=1, ld_err=1, ld_rdata=0.
//  5 reset mid-access: rst pulsed between gnt and rvalid
//    -> no rvalid, all outputs 0; after release a fetch of addr 0 returns ROM[0].
//  6 ROM_ARB_STATS_EN: scenario 2
//    -> stall_cnt=5 (cycles with a waiting requester), 0 after rst.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares a 1-cycle-latency ROM between fetch and load ports, halts on illegal fetch (ROM_ARB_STATS_EN adds o_stall_cnt)
module rom_port_arbiter #(
    parameter int ROM_SIZE   = 512,
    parameter int IP_LIMIT   = 318,
    parameter int STARVE_MAX = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_if_req,
    input  logic [15:0]                 i_if_addr,
    output logic                        o_if_gnt,
    output logic                        o_if_rvalid,
    output logic [31:0]                 o_if_rdata,
    input  logic                        i_ld_req,
    input  logic [15:0]                 i_ld_addr,
    output logic                        o_ld_gnt,
    output logic                        o_ld_rvalid,
    output logic [31:0]                 o_ld_rdata,
    output logic                        o_ld_err,
    output logic                        o_rom_en,
    output logic [$clog2(ROM_SIZE)-1:0] o_rom_addr,
    input  logic [31:0]                 i_rom_rdata,
    output logic                        o_halt,
    output logic [15:0]                 o_halt_addr
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [31:0]                 o_stall_cnt
`endif
);
    localparam int AW = $clog2(ROM_SIZE);
    localparam logic [3:0] SM = STARVE_MAX[3:0];

    if (IP_LIMIT >= ROM_SIZE) begin : g_bad_limit
        $error("IP_LIMIT must be below ROM_SIZE");
    end

    typedef enum logic {RUN, HALT} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_starve;
    logic        r_if_pend, r_ld_pend, r_ld_err;
    logic [31:0] r_if_hold, r_ld_hold;
    logic [15:0] r_halt_addr;
    logic        w_if_bad, w_if_ok, w_ld_range, w_if_gnt, w_ld_gnt;
    logic [31:0] w_ld_data;

    assign w_if_bad   = i_if_req && ({16'd0, i_if_addr} > IP_LIMIT);
    assign w_if_ok    = i_if_req && !w_if_bad;
    assign w_ld_range = {16'd0, i_ld_addr} >= ROM_SIZE;
    assign w_ld_data  = r_ld_err ? 32'd0 : i_rom_rdata;

    // arbitration and next state; grants are suppressed in HALT and while reset is held
    always_comb begin
        w_next   = r_state;
        w_if_gnt = 1'b0;
        w_ld_gnt = 1'b0;
        if (r_state == RUN && !rst) begin
            w_if_gnt = w_if_ok && (!i_ld_req || r_starve == SM);
            w_ld_gnt = i_ld_req && !w_if_gnt;
            if (w_if_bad) w_next = HALT;
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_ld_gnt    = w_ld_gnt;
    assign o_rom_en    = w_if_gnt || (w_ld_gnt && !w_ld_range);
    assign o_rom_addr  = w_if_gnt ? i_if_addr[AW-1:0] : (w_ld_gnt && !w_ld_range) ? i_ld_addr[AW-1:0] : '0;
    assign o_if_rvalid = r_if_pend;
    assign o_if_rdata  = r_if_pend ? i_rom_rdata : r_if_hold;
    assign o_ld_rvalid = r_ld_pend;
    assign o_ld_err    = r_ld_pend && r_ld_err;
    assign o_ld_rdata  = r_ld_pend ? w_ld_data : r_ld_hold;
    assign o_halt      = r_state == HALT;
    assign o_halt_addr = r_halt_addr;

    // state register, return tags, held read data and fetch starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_starve    <= '0;
            r_if_pend   <= 1'b0;
            r_ld_pend   <= 1'b0;
            r_ld_err    <= 1'b0;
            r_if_hold   <= '0;
            r_ld_hold   <= '0;
            r_halt_addr <= '0;
        end else begin
            r_state   <= w_next;
            r_if_pend <= w_if_gnt;
            r_ld_pend <= w_ld_gnt;
            r_ld_err  <= w_ld_gnt && w_ld_range;
            if (r_state == RUN && w_if_bad) r_halt_addr <= i_if_addr;
            if (r_if_pend) r_if_hold <= i_rom_rdata;
            if (r_ld_pend) r_ld_hold <= w_ld_data;
            if (w_if_gnt) r_starve <= '0;
            else if (r_state == RUN && w_if_ok && r_starve != SM) r_starve <= r_starve + 4'd1;
        end
    end

`ifdef ROM_ARB_STATS_EN
    logic [31:0] r_stall_cnt;
    assign o_stall_cnt = r_stall_cnt;

    // one count per RUN cycle in which any requester is left waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_stall_cnt <= '0;
        else if (r_state == RUN && ((i_if_req && !w_if_gnt) || (i_ld_req && !w_ld_gnt))) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed checks of rom_port_arbiter against a behavioural 1-cycle ROM
module tb_rom_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_req = 1'b0;
    logic [15:0] i_if_addr = '0;
    logic        i_ld_req = 1'b0;
    logic [15:0] i_ld_addr = '0;
    logic        o_if_gnt, o_if_rvalid, o_ld_gnt, o_ld_rvalid, o_ld_err, o_rom_en, o_halt;
    logic [31:0] o_if_rdata, o_ld_rdata;
    logic [8:0]  o_rom_addr;
    logic [15:0] o_halt_addr;
    logic [31:0] rom_rdata = '0;
    logic [31:0] rom [512];
`ifdef ROM_ARB_STATS_EN
    logic [31:0] o_stall_cnt;
`endif
    int nvec = 0;
    int nerr = 0;
    logic [4:0] exp_if;

    rom_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .o_ld_gnt(o_ld_gnt),
        .o_ld_rvalid(o_ld_rvalid), .o_ld_rdata(o_ld_rdata), .o_ld_err(o_ld_err),
        .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_rdata(rom_rdata),
        .o_halt(o_halt), .o_halt_addr(o_halt_addr)
`ifdef ROM_ARB_STATS_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (o_rom_en) rom_rdata <= rom[o_rom_addr];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic ir, input logic [15:0] ia, input logic lr, input logic [15:0] la);
        @(negedge clk);
        i_if_req = ir; i_if_addr = ia; i_ld_req = lr; i_ld_addr = la;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 32'hA000_0000 | i;
        rom[0] = 32'h0BAD_F00D;
        rom[5] = 32'hDEAD_BEEF;
        i_if_req = 1'b1; i_if_addr = 16'd5;
        #3;
        chk1("rst if_gnt", o_if_gnt, 1'b0);
        chk1("rst rom_en", o_rom_en, 1'b0);
        chk1("rst halt", o_halt, 1'b0);
        chk1("rst if_rvalid", o_if_rvalid, 1'b0);
        chk32("rst if_rdata", o_if_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drv(1'b0, 16'd0, 1'b0, 16'd0);
        // fetch only
        drv(1'b1, 16'd5, 1'b0, 16'd0);
        chk1("t1 if_gnt", o_if_gnt, 1'b1);
        chk1("t1 ld_gnt", o_ld_gnt, 1'b0);
        chk1("t1 rom_en", o_rom_en, 1'b1);
        chk32("t1 rom_addr", {23'd0, o_rom_addr}, 32'd5);
        drv(1'b0, 16'd0, 1'b0, 16'd0);
        chk1("t1 if_rvalid", o_if_rvalid, 1'b1);
        chk32("t1 if_rdata", o_if_rdata, 32'hDEAD_BEEF);
        chk1("t1 if_gnt off", o_if_gnt, 1'b0);
        drv(1'b0, 16'd0, 1'b0, 16'd0);
        chk1("t1 rvalid pulse", o_if_rvalid, 1'b0);
        chk32("t1 rdata hold", o_if_rdata, 32'hDEAD_BEEF);
        // contention: ld,ld,ld,if,ld
        exp_if = 5'b01000;
        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 16'd16, 1'b1, 16'd32);
            chk1("t2 if_gnt", o_if_gnt, exp_if[k]);
            chk1("t2 ld_gnt", o_ld_gnt, !exp_if[k]);
            if (k > 0) begin
                chk1("t2 if_rvalid", o_if_rvalid, exp_if[k-1]);
                chk1("t2 ld_rvalid", o_ld_rvalid, !exp_if[k-1]);
                if (exp_if[k-1]) chk32("t2 if_rdata", o_if_rdata, 32'hA000_0010);
                else chk32("t2 ld_rdata", o_ld_rdata, 32'hA000_0020);
            end
        end
        drv(1'b0, 16'd0, 1'b0, 16'd0);
        chk1("t2 last ld_rvalid", o_ld_rvalid, 1'b1);
        chk1("t2 last if_rvalid", o_if_rvalid, 1'b0);
        chk32("t2 last ld_rdata", o_ld_rdata, 32'hA000_0020);
`ifdef ROM_ARB_STATS_EN
        chk32("t6 stall_cnt", o_stall_cnt, 32'd5);
`endif
        // load range error
        drv(1'b0, 16'd0, 1'b1, 16'd600);
        chk1("t4 ld_gnt", o_ld_gnt, 1'b1);
        chk1("t4 rom_en", o_rom_en, 1'b0);
        drv(1'b0, 16'd0, 1'b0, 16'd0);
        chk1("t4 ld_rvalid", o_ld_rvalid, 1'b1);
        chk1("t4 ld_err", o_ld_err, 1'b1);
        chk32("t4 ld_rdata", o_ld_rdata, 32'd0);
        drv(1'b0, 16'd0, 1'b1, 16'd511);
        chk1("t4 edge rom_en", o_rom_en, 1'b1);
        drv(1'b0, 16'd0, 1'b0, 16'd0);
        chk1("t4 edge ld_err", o_ld_err, 1'b0);
        chk32("t4 edge ld_rdata", o_ld_rdata, 32'hA000_01FF);
        // reset between grant and return
        drv(1'b1, 16'd7, 1'b0, 16'd0);
        chk1("t5 if_gnt", o_if_gnt, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("t5 rst gnt", o_if_gnt, 1'b0);
        chk1("t5 rst rom_en", o_rom_en, 1'b0);
        @(negedge clk);
        rst = 1'b0; i_if_req = 1'b0;
        #1;
        chk1("t5 no rvalid", o_if_rvalid, 1'b0);
        chk32("t5 if_rdata", o_if_rdata, 32'd0);
        chk32("t5 ld_rdata", o_ld_rdata, 32'd0);
`ifdef ROM_ARB_STATS_EN
        chk32("t6 stall_cnt rst", o_stall_cnt, 32'd0);
`endif
        drv(1'b1, 16'd0, 1'b0, 16'd0);
        chk1("t5 fetch0 gnt", o_if_gnt, 1'b1);
        drv(1'b0, 16'd0, 1'b0, 16'd0);
        chk1("t5 fetch0 rvalid", o_if_rvalid, 1'b1);
        chk32("t5 fetch0 rdata", o_if_rdata, 32'h0BAD_F00D);
        // highest legal fetch
        drv(1'b1, 16'd318, 1'b0, 16'd0);
        chk1("t3 318 gnt", o_if_gnt, 1'b1);
        drv(1'b0, 16'd0, 1'b0, 16'd0);
        chk32("t3 318 rdata", o_if_rdata, 32'hA000_013E);
        chk1("t3 318 halt", o_halt, 1'b0);
        // illegal fetch with a legal load in the same cycle
        drv(1'b1, 16'd319, 1'b1, 16'd10);
        chk1("t3 if_gnt", o_if_gnt, 1'b0);
        chk1("t3 ld_gnt", o_ld_gnt, 1'b1);
        chk32("t3 rom_addr", {23'd0, o_rom_addr}, 32'd10);
        chk1("t3 halt early", o_halt, 1'b0);
        drv(1'b1, 16'd3, 1'b1, 16'd10);
        chk1("t3 halt", o_halt, 1'b1);
        chk32("t3 halt_addr", {16'd0, o_halt_addr}, 32'd319);
        chk1("t3 inflight rvalid", o_ld_rvalid, 1'b1);
        chk32("t3 inflight rdata", o_ld_rdata, 32'hA000_000A);
        chk1("t3 halted if_gnt", o_if_gnt, 1'b0);
        chk1("t3 halted ld_gnt", o_ld_gnt, 1'b0);
        chk1("t3 halted rom_en", o_rom_en, 1'b0);
        drv(1'b1, 16'd3, 1'b1, 16'd10);
        chk1("t3 sticky halt", o_halt, 1'b1);
        chk1("t3 no rvalid", o_ld_rvalid, 1'b0);
        chk32("t3 sticky halt_addr", {16'd0, o_halt_addr}, 32'd319);
        @(negedge clk);
        rst = 1'b1; i_if_req = 1'b0; i_ld_req = 1'b0;
        #1;
        chk1("t3 rst halt", o_halt, 1'b0);
        chk32("t3 rst halt_addr", {16'd0, o_halt_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
